// File: rtl/core_inst_seq.sv
// Instruction sequencer for one attention core: issues a complete tile pass as a registered
// inst word, from K/Q writes through MAC load/execute, psum drain and the SFP pass into norm memory.
module core_inst_seq #(
    parameter int col    = 8,
    parameter int inst_w = 29
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        len,
    input  logic              bank_sel,
    input  logic              fifo_valid,
    output logic [inst_w-1:0] inst,
    output logic              mem_req,
    output logic              busy,
    output logic              done
);

    localparam int PMEM_WR       = 0;
    localparam int PMEM_RD       = 1;
    localparam int KMEM_WR_E     = 2;
    localparam int KMEM_WR_O     = 3;
    localparam int KMEM_RD_E     = 4;
    localparam int KMEM_RD_O     = 5;
    localparam int QMEM_WR_E     = 6;
    localparam int QMEM_WR_O     = 7;
    localparam int QMEM_RD_E     = 8;
    localparam int QMEM_RD_O     = 9;
    localparam int PMEM_ADD_LSB  = 10;
    localparam int QKMEM_ADD_LSB = 14;
    localparam int OFIFO_RD      = 18;
    localparam int MAC_LOADK     = 19;
    localparam int MAC_EXE       = 20;
    localparam int NORM_WR       = 21;
    localparam int NORM_ADD_LSB  = 23;
    localparam int SFP_LSB       = 27;

    localparam logic [1:0] SFP_READ  = 2'b01;
    localparam logic [1:0] SFP_WRITE = 2'b10;
    localparam logic [3:0] COL_LAST  = 4'(col - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_KWR,
        S_QWR,
        S_KLD,
        S_GAP,
        S_QEX,
        S_WAIT,
        S_OFR,
        S_PRD,
        S_NWR,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        len_q, len_d;
    logic              bank_q, bank_d;
    logic [inst_w-1:0] inst_q, inst_d;
    logic              mem_req_q, mem_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              last_col;
    logic              last_n;

    assign last_col = (cnt_q == COL_LAST);
    assign last_n   = (cnt_q == len_q);

    // Phase sequencing; every phase entry restarts the shared address counter at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        bank_d  = bank_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_KWR;
                    cnt_d   = 4'd0;
                    len_d   = len;
                    bank_d  = bank_sel;
                end
            end
            S_KWR: begin
                if (last_col) begin
                    state_d = S_QWR;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_QWR: begin
                if (last_n) begin
                    state_d = S_KLD;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_KLD: begin
                if (last_col) begin
                    state_d = S_GAP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_GAP: begin
                state_d = S_QEX;
                cnt_d   = 4'd0;
            end
            S_QEX: begin
                if (last_n) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (fifo_valid) begin
                    state_d = S_OFR;
                    cnt_d   = 4'd0;
                end
            end
            S_OFR: begin
                if (last_n) begin
                    state_d = S_PRD;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_PRD: begin
                if (last_n) begin
                    state_d = S_NWR;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_NWR: begin
                if (last_n) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        inst_d    = '0;
        mem_req_d = 1'b0;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);

        unique case (state_d)
            S_KWR: begin
                inst_d[KMEM_WR_E]              = ~bank_d;
                inst_d[KMEM_WR_O]              = bank_d;
                inst_d[QKMEM_ADD_LSB +: 4]     = cnt_d;
                mem_req_d                      = 1'b1;
            end
            S_QWR: begin
                inst_d[QMEM_WR_E]              = ~bank_d;
                inst_d[QMEM_WR_O]              = bank_d;
                inst_d[QKMEM_ADD_LSB +: 4]     = cnt_d;
                mem_req_d                      = 1'b1;
            end
            S_KLD: begin
                inst_d[KMEM_RD_E]              = ~bank_d;
                inst_d[KMEM_RD_O]              = bank_d;
                inst_d[MAC_LOADK]              = 1'b1;
                inst_d[QKMEM_ADD_LSB +: 4]     = cnt_d;
            end
            S_QEX: begin
                inst_d[QMEM_RD_E]              = ~bank_d;
                inst_d[QMEM_RD_O]              = bank_d;
                inst_d[MAC_EXE]                = 1'b1;
                inst_d[QKMEM_ADD_LSB +: 4]     = cnt_d;
            end
            S_OFR: begin
                inst_d[OFIFO_RD]               = 1'b1;
                inst_d[PMEM_WR]                = 1'b1;
                inst_d[PMEM_ADD_LSB +: 4]      = cnt_d;
            end
            S_PRD: begin
                inst_d[PMEM_RD]                = 1'b1;
                inst_d[PMEM_ADD_LSB +: 4]      = cnt_d;
                inst_d[SFP_LSB +: 2]           = SFP_READ;
            end
            S_NWR: begin
                inst_d[NORM_WR]                = 1'b1;
                inst_d[NORM_ADD_LSB +: 4]      = cnt_d;
                inst_d[SFP_LSB +: 2]           = SFP_WRITE;
            end
            default: begin
                inst_d    = '0;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            len_q     <= 4'd0;
            bank_q    <= 1'b0;
            inst_q    <= '0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            bank_q    <= bank_d;
            inst_q    <= inst_d;
            mem_req_q <= mem_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign inst    = inst_q;
    assign mem_req = mem_req_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: expected per-cycle outputs of each pass are queued when start is
// driven and popped against the DUT one cycle at a time.
module tb_core_inst_seq;

    localparam int COL = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  len;
    logic        bank_sel;
    logic        fifo_valid;
    logic [28:0] inst;
    logic        mem_req;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [28:0] inst;
        logic        mem_req;
        logic        busy;
        logic        done;
    } out_t;

    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    core_inst_seq #(.col(COL), .inst_w(29)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .bank_sel   (bank_sel),
        .fifo_valid (fifo_valid),
        .inst       (inst),
        .mem_req    (mem_req),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic [28:0] i, input logic m, input logic b, input logic d);
        out_t o;
        o.inst    = i;
        o.mem_req = m;
        o.busy    = b;
        o.done    = d;
        return o;
    endfunction

    // Flat per-cycle list of a whole pass, built directly from the field map.
    task automatic push_pass(input int n, input bit bank, input int waits);
        for (int a = 0; a < COL; a++)
            exp_q.push_back(mk((29'd1 << (2 + bank)) | (29'(a) << 14), 1'b1, 1'b1, 1'b0));
        for (int a = 0; a < n; a++)
            exp_q.push_back(mk((29'd1 << (6 + bank)) | (29'(a) << 14), 1'b1, 1'b1, 1'b0));
        for (int a = 0; a < COL; a++)
            exp_q.push_back(mk((29'd1 << (4 + bank)) | (29'd1 << 19) | (29'(a) << 14), 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(29'd0, 1'b0, 1'b1, 1'b0));
        for (int a = 0; a < n; a++)
            exp_q.push_back(mk((29'd1 << (8 + bank)) | (29'd1 << 20) | (29'(a) << 14), 1'b0, 1'b1, 1'b0));
        for (int w = 0; w < waits; w++)
            exp_q.push_back(mk(29'd0, 1'b0, 1'b1, 1'b0));
        for (int a = 0; a < n; a++)
            exp_q.push_back(mk((29'd1 << 18) | 29'd1 | (29'(a) << 10), 1'b0, 1'b1, 1'b0));
        for (int a = 0; a < n; a++)
            exp_q.push_back(mk(29'd2 | (29'(a) << 10) | (29'd1 << 27), 1'b0, 1'b1, 1'b0));
        for (int a = 0; a < n; a++)
            exp_q.push_back(mk((29'd2 << 27) | (29'd1 << 21) | (29'(a) << 23), 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(29'd0, 1'b0, 1'b1, 1'b1));
        exp_q.push_back(mk(29'd0, 1'b0, 1'b0, 1'b0));
    endtask

    // pulse: stray starts in QEX and DONE; chain: hold start into the idle cycle after done.
    task automatic run_pass(input int lenv, input bit bank, input int waits,
                            input bit pulse, input bit chain, input int stop_after);
        int   n;
        int   qex0;
        int   w0;
        int   done_idx;
        int   busy_cnt;
        int   done_cnt;
        out_t e;
        out_t o;
        n        = lenv + 1;
        qex0     = 2 * COL + n + 1;
        w0       = 2 * COL + 2 * n + 1;
        busy_cnt = 0;
        done_cnt = 0;
        exp_q.delete();
        push_pass(n, bank, waits);
        done_idx   = exp_q.size() - 2;
        len        = 4'(lenv);
        bank_sel   = bank;
        start      = 1'b1;
        fifo_valid = (waits == 1);
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            o = {inst, mem_req, busy, done};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("[TB] FAIL pass_len%0d_bank%0d idx=%0d: got inst=%h mem_req=%b busy=%b done=%b, expected inst=%h mem_req=%b busy=%b done=%b",
                         lenv, bank, idx, o.inst, o.mem_req, o.busy, o.done,
                         e.inst, e.mem_req, e.busy, e.done);
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            start      = (pulse && (idx == qex0 || idx == done_idx)) || (chain && idx == done_idx + 1);
            fifo_valid = (waits == 1) ? 1'b1 : (idx == w0 + waits - 1);
            if (idx == stop_after) begin
                exp_q.delete();
                return;
            end
        end
        n_cmp++;
        if (busy_cnt != 2 * COL + 5 * n + 2 + waits) begin
            n_bad++;
            $display("[TB] FAIL busy_len len%0d: got %0d cycles, expected %0d",
                     lenv, busy_cnt, 2 * COL + 5 * n + 2 + waits);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("[TB] FAIL done_pulses len%0d: got %0d, expected 1", lenv, done_cnt);
        end
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({inst, mem_req, busy, done} !== 32'd0) begin
            n_bad++;
            $display("[TB] FAIL %s: got inst=%h mem_req=%b busy=%b done=%b, expected all 0",
                     name, inst, mem_req, busy, done);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b0;
        len        = 4'd0;
        bank_sel   = 1'b0;
        fifo_valid = 1'b0;
        @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("idle_after_reset");
        end
    endtask

    task automatic test_basic();
        run_pass(7, 1'b0, 1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_bank_odd();
        run_pass(0, 1'b1, 1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_len_max();
        run_pass(15, 1'b0, 1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_fifo_wait();
        run_pass(3, 1'b1, 10, 1'b0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        run_pass(2, 1'b0, 1, 1'b1, 1'b1, -1);
        run_pass(5, 1'b1, 1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        int n;
        n = 5;
        run_pass(n - 1, 1'b0, 1, 1'b0, 1'b0, 2 * COL + 2 * n + 1 + 1 + 2);
        reset = 1'b1;
        #1;
        check_zero("reset_async_in_ofr");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_zero("reset_held");
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("idle_after_mid_reset");
        end
        run_pass(7, 1'b1, 1, 1'b0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bank_odd();
        test_len_max();
        test_fifo_wait();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_inst_seq.md
# core_inst_seq

Instruction sequencer that drives the 29-bit `inst` word of one attention core. It issues one complete tile pass: K write, Q write, K load into the MAC array, Q execute, output-FIFO drain into psum memory, then SFP pass into norm memory. It sits between the top-level testbench/host and the core. It supplies the other end of the core's instruction interface and the data-request strobe for `mem_in`.

## Interface
Parameters:
- `col`, 8: MAC columns; number of K vectors written and loaded.
- `inst_w`, 29: instruction width.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `start` in 1: request a pass; sampled only in IDLE.
- `len` in 4: number of Q vectors minus one (N = len+1, 1..16); latched on accepted start.
- `bank_sel` in 1: 0 = even SRAM banks, 1 = odd banks; latched on accepted start.
- `fifo_valid` in 1: core output FIFO holds data.
- `inst` out 29: registered instruction word to the core.
- `mem_req` out 1: registered; host must present the next `mem_in` word in the same cycle `inst` carries a K/Q write.
- `busy` out 1: high from the cycle after start is accepted until DONE completes.
- `done` out 1: one-cycle pulse at pass end.

## Operation
- Inst field map (decided): [0] pmem_wr, [1] pmem_rd, [2]/[3] kmem even/odd wr, [4]/[5] kmem even/odd rd, [6]/[7] qmem even/odd wr, [8]/[9] qmem even/odd rd, [13:10] pmem_add, [17:14] qkmem_add, [18] ofifo_rd, [19] mac_loadk, [20] mac_exe, [21] norm_mem_wr, [22] norm_mem_rd, [26:23] norm_mem_addr, [28:27] sfp_inst. Unused bits are 0 in every state.
- The even/odd bit of each K/Q field comes from latched `bank_sel`.
- A single 4-bit counter `cnt` provides the address in each phase. It restarts at 0 on each phase entry.
- States and the inst each issues:
  - IDLE: inst=0. On start, go to KWR.
  - KWR, `col` cycles: kmem_wr=1, qkmem_add=cnt, mem_req=1.
  - QWR, N cycles: qmem_wr=1, qkmem_add=cnt, mem_req=1.
  - KLD, `col` cycles: kmem_rd=1, mac_loadk=1, qkmem_add=cnt.
  - GAP, 1 cycle: inst=0.
  - QEX, N cycles: qmem_rd=1, mac_exe=1, qkmem_add=cnt.
  - WAIT: inst=0 until `fifo_valid`=1 is sampled, then go to OFR. There is no timeout.
  - OFR, N cycles: ofifo_rd=1, pmem_wr=1, pmem_add=cnt. FIFO head is written in the same cycle.
  - PRD, N cycles: pmem_rd=1, pmem_add=cnt, sfp_inst=2'b01.
  - NWR, N cycles: sfp_inst=2'b10, norm_mem_wr=1, norm_mem_addr=cnt.
  - DONE, 1 cycle: inst=0, done=1. Then go to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor latched.
- `fifo_valid` is ignored outside WAIT. Dropping `fifo_valid` during OFR does not stall the sequence.

## Timing
- Reset values: inst=0, mem_req=0, busy=0, done=0, state=IDLE, cnt=0, latched len/bank_sel=0.
- Start sampled high in IDLE at edge t: the first KWR inst is valid after edge t+1. busy rises at the same edge.
- All outputs are registered. State, inst and mem_req change on the same edge. Phase boundaries have no bubble, except GAP and WAIT.
- Pass length with fifo_valid already high on WAIT entry: 2·col + 5N + 3 cycles of busy. WAIT contributes 1 cycle minimum. For col=8, N=8: 59.
- Address wrap: N=16 uses addresses 0..15 with no wrap. cnt never exceeds N−1 or col−1.
- The last cycle of busy coincides with done. busy=0 in the cycle after done.
- Start high in the same cycle done is high: ignored (state is DONE, not IDLE). Start one cycle later: accepted.
- Reset asserted mid-pass: outputs go to 0 asynchronously, with no completion pulse. The next pass needs a fresh start after reset deasserts.

## Test plan
- Reset, then idle: inst, mem_req, busy, done all 0. Start with len=7, bank_sel=0, fifo_valid tied 1 → KWR inst=0x4 with qkmem_add 0..7, then QWR 0x40|add<<14. busy lasts 59 cycles, with exactly one done pulse.
- bank_sel=1, len=0 → KWR uses bit3, QWR bit7, KLD bit5, QEX bit9. Each Q-side phase lasts 1 cycle.
- len=15 → QEX/OFR/PRD/NWR each 16 cycles, with addresses 0..15 and no wrap. Field [26:23]=15 on the last NWR cycle.
- Hold fifo_valid low for 10 cycles after QEX → inst=0 for 10 WAIT cycles. OFR begins the cycle after fifo_valid is sampled high.
- Pulse start during QEX and during DONE → ignored, no second pass. Start the cycle after done → new pass accepted.
- Assert reset during OFR → inst=0 immediately, busy=0, no done. After release, a new start runs a full pass correctly.
